array_2x2: RTL and testbench

//   2x2 weight-stationary systolic MAC array built from four PEs.

---
 rtl/array_2x2.sv | 77 +++++++
 tb/tb_array_2x2.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/array_2x2.sv
`default_nettype none
// ============================================================================
// Module   : array_2x2
// Purpose  : 2x2 weight-stationary systolic MAC array (four PEs). Weights
//            shift in from the left edge of each row while load is high;
//            activations then flow left-to-right and partial sums flow
//            top-to-bottom, giving y = init + x*W per column.
// Revision : 1.0 - initial release
// ============================================================================
module array_2x2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,          // asynchronous, active-low
    input  logic             load,
    input  logic [WIDTH-1:0] row_1_load,
    input  logic [WIDTH-1:0] row_2_load,
    input  logic [WIDTH-1:0] row_1_data,
    input  logic [WIDTH-1:0] row_2_data,
    input  logic [WIDTH-1:0] col_1_initial,
    input  logic [WIDTH-1:0] col_2_initial,
    output logic [WIDTH-1:0] col_1_out,
    output logic [WIDTH-1:0] col_2_out
);

    // Stationary weights, PE(r,c) -> w_rc
    logic [WIDTH-1:0] w11, w12, w21, w22;

    // Activation pass-through registers. The right-hand column's activation
    // register has no consumer inside a 2x2 tile, so only column 1 keeps one.
    logic [WIDTH-1:0] a11, a21;

    // Partial-sum registers
    logic [WIDTH-1:0] p11, p12, p21, p22;

    // Weight shift chain: while loading, each row shifts one place right so
    // the first value presented ends up in column 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w11 <= '0;
            w12 <= '0;
            w21 <= '0;
            w22 <= '0;
        end else if (load) begin
            w12 <= w11;
            w11 <= row_1_load;
            w22 <= w21;
            w21 <= row_2_load;
        end
    end

    // MAC pipeline: advances only while computing; load freezes it in place.
    // Products and sums are computed at WIDTH bits, so they wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a11 <= '0;
            a21 <= '0;
            p11 <= '0;
            p12 <= '0;
            p21 <= '0;
            p22 <= '0;
        end else if (!load) begin
            a11 <= row_1_data;
            a21 <= row_2_data;
            p11 <= col_1_initial + row_1_data * w11;
            p12 <= col_2_initial + a11 * w12;
            p21 <= p11 + row_2_data * w21;
            p22 <= p12 + a21 * w22;
        end
    end

    // Bottom-of-column partial sums are the tile outputs.
    assign col_1_out = p21;
    assign col_2_out = p22;

endmodule
`default_nettype wire

// File: tb/tb_array_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_2x2
// Purpose  : Self-checking bench for array_2x2. Column results are predicted
//            from y = c + x*W (mod 256) and the documented skew/latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_2x2;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] row_1_load, row_2_load;
    logic [WIDTH-1:0] row_1_data, row_2_data;
    logic [WIDTH-1:0] col_1_initial, col_2_initial;
    logic [WIDTH-1:0] col_1_out, col_2_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference weights held by the model
    int wm11, wm12, wm21, wm22;

    // Vector stream for the model: x1, x2, c1, c2 per vector
    int vx1[$], vx2[$], vc1[$], vc2[$];

    array_2x2 #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .row_1_load    (row_1_load),
        .row_2_load    (row_2_load),
        .row_1_data    (row_1_data),
        .row_2_data    (row_2_data),
        .col_1_initial (col_1_initial),
        .col_2_initial (col_2_initial),
        .col_1_out     (col_1_out),
        .col_2_out     (col_2_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int y1_of(int k);
        return (vc1[k] + vx1[k] * wm11 + vx2[k] * wm21) & 255;
    endfunction

    function automatic int y2_of(int k);
        return (vc2[k] + vx1[k] * wm12 + vx2[k] * wm22) & 255;
    endfunction

    // Two load edges: the first pair lands in column 2, the second in column 1.
    task automatic load_weights(input int w11, input int w12,
                                input int w21, input int w22);
        logic [WIDTH-1:0] h1, h2;
        h1 = col_1_out;
        h2 = col_2_out;
        load       = 1'b1;
        row_1_load = WIDTH'(w12);
        row_2_load = WIDTH'(w22);
        row_1_data = WIDTH'($urandom);
        row_2_data = WIDTH'($urandom);
        step();
        row_1_load = WIDTH'(w11);
        row_2_load = WIDTH'(w21);
        step();
        check("load_hold_c1", col_1_out, h1);
        check("load_hold_c2", col_2_out, h2);
        load = 1'b0;
        wm11 = w11; wm12 = w12; wm21 = w21; wm22 = w22;
    endtask

    task automatic clear_stream();
        vx1.delete(); vx2.delete(); vc1.delete(); vc2.delete();
    endtask

    task automatic push_vec(input int x1, input int x2, input int c1, input int c2);
        vx1.push_back(x1); vx2.push_back(x2);
        vc1.push_back(c1); vc2.push_back(c2);
    endtask

    // Issue the queued vectors back-to-back with the skewed schedule, then two
    // zero vectors to drain. stall_pct inserts load cycles (weights must be
    // equal along each row so the shift leaves them unchanged).
    task automatic run_stream(input string tag, input int stall_pct);
        int  e1, e2;
        bit  k1, k2;
        int  nv;
        k1 = 0; k2 = 0; e1 = 0; e2 = 0;
        push_vec(0, 0, 0, 0);
        push_vec(0, 0, 0, 0);
        nv = vx1.size();
        for (int n = 0; n < nv; n++) begin
            if (n > 0 && $urandom_range(99) < stall_pct) begin
                load          = 1'b1;
                row_1_load    = WIDTH'(wm11);
                row_2_load    = WIDTH'(wm21);
                row_1_data    = WIDTH'($urandom);
                row_2_data    = WIDTH'($urandom);
                col_1_initial = WIDTH'($urandom);
                col_2_initial = WIDTH'($urandom);
                step();
                if (k1) check({tag, "_stall_c1"}, col_1_out, WIDTH'(e1));
                if (k2) check({tag, "_stall_c2"}, col_2_out, WIDTH'(e2));
            end
            load          = 1'b0;
            row_1_data    = WIDTH'(vx1[n]);
            col_1_initial = WIDTH'(vc1[n]);
            row_2_data    = (n > 0) ? WIDTH'(vx2[n-1]) : '0;
            col_2_initial = (n > 0) ? WIDTH'(vc2[n-1]) : '0;
            step();
            if (n >= 1) begin e1 = y1_of(n - 1); k1 = 1; end
            if (n >= 2) begin e2 = y2_of(n - 2); k2 = 1; end
            if (k1) check({tag, "_c1"}, col_1_out, WIDTH'(e1));
            if (k2) check({tag, "_c2"}, col_2_out, WIDTH'(e2));
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0;
        row_1_load = '0; row_2_load = '0;
        row_1_data = '0; row_2_data = '0;
        col_1_initial = '0; col_2_initial = '0;

        // Asynchronous reset between edges
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_c1", col_1_out, '0);
        check("reset_c2", col_2_out, '0);
        step();
        reset = 1'b1;

        // Directed load and the two back-to-back example vectors
        load_weights(1, 2, 3, 4);
        check("postload_c1", col_1_out, '0);
        check("postload_c2", col_2_out, '0);
        clear_stream();
        push_vec(1, 0, 2, 2);
        push_vec(0, 1, 0, 0);
        run_stream("ex", 0);

        // Wrap-around: 3 + 2*255 = 513 -> 1
        load_weights(255, 9, 17, 6);
        clear_stream();
        push_vec(2, 0, 3, 5);
        run_stream("wrap", 0);

        // Random weights and vectors at full throughput
        load_weights($urandom_range(255), $urandom_range(255),
                     $urandom_range(255), $urandom_range(255));
        clear_stream();
        for (int i = 0; i < 24; i++)
            push_vec($urandom_range(255), $urandom_range(255),
                     $urandom_range(255), $urandom_range(255));
        run_stream("rand", 0);

        // Random stream with load stalls mid-flight
        begin
            int ra, rb;
            ra = $urandom_range(255);
            rb = $urandom_range(255);
            load_weights(ra, ra, rb, rb);
        end
        clear_stream();
        for (int i = 0; i < 24; i++)
            push_vec($urandom_range(255), $urandom_range(255),
                     $urandom_range(255), $urandom_range(255));
        run_stream("stall", 35);

        // Reset mid-stream clears pipeline and weights
        load_weights(7, 11, 13, 5);
        load = 1'b0;
        row_1_data = 8'd3; col_1_initial = 8'd5;
        row_2_data = 8'd4; col_2_initial = 8'd6;
        step();
        step();
        #1 reset = 1'b0;
        #1;
        check("midreset_c1", col_1_out, '0);
        check("midreset_c2", col_2_out, '0);
        step();
        reset = 1'b1;
        wm11 = 0; wm12 = 0; wm21 = 0; wm22 = 0;
        clear_stream();
        for (int i = 0; i < 8; i++)
            push_vec($urandom_range(255), $urandom_range(255),
                     $urandom_range(255), $urandom_range(255));
        run_stream("noweights", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
